// File: rtl/dbi_tx_sequencer.sv
// DBI command/pixel transmit sequencer: optional hard reset and stall, access control,
// column/row window, display-on, then a MEM_WR burst of the window's pixel bytes.
module dbi_tx_sequencer #(
  parameter int DBI_IF_D_W    = 8,
  parameter int COORD_W       = 16,
  parameter int RST_STALL_CYC = 625000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  init_mode_i,
  input  logic                  cont_i,
  input  logic                  stop_i,
  input  logic [DBI_IF_D_W-1:0] addr_col_i,
  input  logic [DBI_IF_D_W-1:0] addr_row_i,
  input  logic [DBI_IF_D_W-1:0] addr_acs_ctrl_i,
  input  logic [DBI_IF_D_W-1:0] addr_disp_on_i,
  input  logic [DBI_IF_D_W-1:0] addr_mem_wr_i,
  input  logic [DBI_IF_D_W-1:0] cmd_acs_ctrl_i,
  input  logic [COORD_W-1:0]    s_col_i,
  input  logic [COORD_W-1:0]    e_col_i,
  input  logic [COORD_W-1:0]    s_row_i,
  input  logic [COORD_W-1:0]    e_row_i,
  input  logic [1:0]            bpp_i,
  input  logic [DBI_IF_D_W-1:0] pxl_d_i,
  input  logic                  pxl_vld_i,
  output logic                  pxl_rdy_o,
  input  logic                  dtp_tx_rdy_i,
  output logic                  dtp_dbi_hrst_o,
  output logic                  dtp_tx_last_o,
  output logic                  dtp_tx_no_dat_o,
  output logic                  dtp_tx_vld_o,
  output logic [DBI_IF_D_W-1:0] dtp_tx_cmd_typ_o,
  output logic [DBI_IF_D_W-1:0] dtp_tx_cmd_dat_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  cfg_err_o
);

  localparam int CNT_W   = 2*COORD_W+2;
  localparam int STALL_W = $clog2(RST_STALL_CYC+1);

  typedef enum logic [2:0] {
    S_IDLE, S_HRST, S_STALL, S_ACS, S_COL, S_ROW, S_DISP, S_MEMWR
  } state_t;

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   s_col_q, s_col_d, e_col_q, e_col_d;
  logic [COORD_W-1:0]   s_row_q, s_row_d, e_row_q, e_row_d;
  logic [1:0]           bpp_q, bpp_d;
  logic                 cont_q, cont_d;
  logic                 init_q, init_d;
  logic                 stop_q, stop_d;
  logic [1:0]           beat_q, beat_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     n_q, n_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 cfg_ok;
  logic                 hs;
  logic                 mem_last;
  logic [COORD_W:0]     n_cols, n_rows;
  logic [CNT_W-1:0]     n_calc;
  logic [15:0]          win_s, win_e;
  logic [7:0]           win_byte;

  assign cfg_ok = (e_col_i >= s_col_i) && (e_row_i >= s_row_i) && (bpp_i != 2'd0);
  assign hs     = dtp_tx_vld_o & dtp_tx_rdy_i;

  // 3 * (2^COORD_W)^2 always fits in 2*COORD_W+2 bits, so no product can wrap
  assign n_cols = {1'b0, e_col_q} - {1'b0, s_col_q} + (COORD_W+1)'(1);
  assign n_rows = {1'b0, e_row_q} - {1'b0, s_row_q} + (COORD_W+1)'(1);
  assign n_calc = CNT_W'(n_cols) * CNT_W'(n_rows) * CNT_W'(bpp_q);

  assign mem_last = (cnt_q == n_q - CNT_W'(1));

  assign win_s = (state_q == S_ROW) ? 16'(s_row_q) : 16'(s_col_q);
  assign win_e = (state_q == S_ROW) ? 16'(e_row_q) : 16'(e_col_q);

  always_comb begin
    win_byte = 8'h00;
    case (beat_q)
      2'd0:    win_byte = win_s[15:8];
      2'd1:    win_byte = win_s[7:0];
      2'd2:    win_byte = win_e[15:8];
      default: win_byte = win_e[7:0];
    endcase
  end

  assign busy_o    = (state_q != S_IDLE);
  assign cfg_err_o = cfg_err_q;

  always_comb begin
    state_d   = state_q;
    s_col_d   = s_col_q;
    e_col_d   = e_col_q;
    s_row_d   = s_row_q;
    e_row_d   = e_row_q;
    bpp_d     = bpp_q;
    cont_d    = cont_q;
    init_d    = init_q;
    stop_d    = stop_q | (stop_i & (state_q != S_IDLE));
    beat_d    = beat_q;
    stall_d   = stall_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    cfg_err_d = 1'b0;

    pxl_rdy_o        = 1'b0;
    dtp_dbi_hrst_o   = 1'b0;
    dtp_tx_last_o    = 1'b0;
    dtp_tx_no_dat_o  = 1'b0;
    dtp_tx_vld_o     = 1'b0;
    dtp_tx_cmd_typ_o = '0;
    dtp_tx_cmd_dat_o = '0;
    frame_done_o     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (cfg_ok) begin
            s_col_d = s_col_i;
            e_col_d = e_col_i;
            s_row_d = s_row_i;
            e_row_d = e_row_i;
            bpp_d   = bpp_i;
            cont_d  = cont_i;
            init_d  = init_mode_i;
            beat_d  = 2'd0;
            state_d = init_mode_i ? S_HRST : S_COL;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_HRST: begin
        dtp_tx_vld_o   = 1'b1;
        dtp_dbi_hrst_o = 1'b1;
        if (hs) begin
          stall_d = STALL_W'(RST_STALL_CYC-1);
          state_d = S_STALL;
        end
      end
      S_STALL: begin
        if (stall_q == '0) state_d = S_ACS;
        else               stall_d = stall_q - STALL_W'(1);
      end
      S_ACS: begin
        dtp_tx_vld_o     = 1'b1;
        dtp_tx_last_o    = 1'b1;
        dtp_tx_cmd_typ_o = addr_acs_ctrl_i;
        dtp_tx_cmd_dat_o = cmd_acs_ctrl_i;
        if (hs) begin
          beat_d  = 2'd0;
          state_d = S_COL;
        end
      end
      S_COL, S_ROW: begin
        dtp_tx_vld_o     = 1'b1;
        dtp_tx_last_o    = (beat_q == 2'd3);
        dtp_tx_cmd_typ_o = (state_q == S_ROW) ? addr_row_i : addr_col_i;
        dtp_tx_cmd_dat_o = DBI_IF_D_W'(win_byte);
        if (hs) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            if (state_q == S_COL) begin
              state_d = S_ROW;
            end else if (init_q) begin
              state_d = S_DISP;
            end else begin
              n_d     = n_calc;
              cnt_d   = '0;
              state_d = S_MEMWR;
            end
          end
        end
      end
      S_DISP: begin
        dtp_tx_vld_o     = 1'b1;
        dtp_tx_last_o    = 1'b1;
        dtp_tx_no_dat_o  = 1'b1;
        dtp_tx_cmd_typ_o = addr_disp_on_i;
        if (hs) begin
          init_d  = 1'b0;
          n_d     = n_calc;
          cnt_d   = '0;
          state_d = S_MEMWR;
        end
      end
      S_MEMWR: begin
        dtp_tx_vld_o     = pxl_vld_i;
        pxl_rdy_o        = dtp_tx_rdy_i;
        dtp_tx_last_o    = mem_last;
        dtp_tx_cmd_typ_o = addr_mem_wr_i;
        dtp_tx_cmd_dat_o = pxl_d_i;
        if (hs) begin
          if (mem_last) begin
            frame_done_o = 1'b1;
            cnt_d        = '0;
            // a stop arriving on the final beat still counts as pending
            if (cont_q && start_i && !stop_q && !stop_i) begin
              if (cfg_ok) begin
                s_col_d = s_col_i;
                e_col_d = e_col_i;
                s_row_d = s_row_i;
                e_row_d = e_row_i;
                bpp_d   = bpp_i;
                beat_d  = 2'd0;
                state_d = S_COL;
              end else begin
                cfg_err_d = 1'b1;
                state_d   = S_IDLE;
              end
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) stop_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      s_col_q   <= '0;
      e_col_q   <= '0;
      s_row_q   <= '0;
      e_row_q   <= '0;
      bpp_q     <= '0;
      cont_q    <= 1'b0;
      init_q    <= 1'b0;
      stop_q    <= 1'b0;
      beat_q    <= '0;
      stall_q   <= '0;
      cnt_q     <= '0;
      n_q       <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_col_q   <= s_col_d;
      e_col_q   <= e_col_d;
      s_row_q   <= s_row_d;
      e_row_q   <= e_row_d;
      bpp_q     <= bpp_d;
      cont_q    <= cont_d;
      init_q    <= init_d;
      stop_q    <= stop_d;
      beat_q    <= beat_d;
      stall_q   <= stall_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      cfg_err_q <= cfg_err_d;
    end
  end

endmodule

// File: doc/dbi_tx_sequencer.md
DBI_TX_SEQUENCER -- requirements
Module: dbi_tx_sequencer

Interface
REQ-001 SHALL have parameter DBI_IF_D_W, default 8, DBI bus byte width.
REQ-002 SHALL have parameter COORD_W, default 16, window coordinate width.
REQ-003 SHALL have parameter RST_STALL_CYC, default 625000, post-reset stall cycles (5 ms at 125 MHz); minimum 1.
REQ-004 SHALL use derived width CNT_W = 2*COORD_W+2 for the MEM_WR byte counter.
REQ-005 Ports SHALL be (name, direction, width, meaning):
 clk  in  1  sole clock, rising edge
 rst  in  1  synchronous, active-high reset
 start_i  in  1  level; frame request
 init_mode_i  in  1  1: hard reset + stall + access-control before window; 0: window update only
 cont_i  in  1  1: continuous frames; 0: single frame
 stop_i  in  1  request stop at the next frame end
 addr_col_i / addr_row_i / addr_acs_ctrl_i / addr_disp_on_i / addr_mem_wr_i  in  DBI_IF_D_W each  command codes
 cmd_acs_ctrl_i  in  DBI_IF_D_W  access-control parameter
 s_col_i / e_col_i / s_row_i / e_row_i  in  COORD_W each  inclusive window bounds
 bpp_i  in  2  bytes per pixel, legal values 1..3
 pxl_d_i  in  DBI_IF_D_W  pixel byte
 pxl_vld_i  in  1  pixel byte valid
 pxl_rdy_o  out  1  pixel byte accepted
 dtp_tx_rdy_i  in  1  PHY ready
 dtp_dbi_hrst_o / dtp_tx_last_o / dtp_tx_no_dat_o / dtp_tx_vld_o  out  1 each  PHY controls
 dtp_tx_cmd_typ_o / dtp_tx_cmd_dat_o  out  DBI_IF_D_W each  command code / data byte
 busy_o  out  1  high whenever state is not IDLE
 frame_done_o  out  1  one-cycle pulse on the last MEM_WR handshake
 cfg_err_o  out  1  one-cycle pulse when a start is rejected

Function
REQ-006 States SHALL be IDLE, HRST, STALL, ACS, COL, ROW, DISP, MEMWR.
REQ-007 Handshake SHALL complete on a cycle with dtp_tx_vld_o & dtp_tx_rdy_i; all PHY outputs SHALL be combinational from state, latched configuration and counters.
REQ-008 In IDLE with start_i=1, the block SHALL latch the window, bpp_i, init_mode_i and cont_i, and go to HRST if init_mode_i=1, else to COL.
REQ-009 A start SHALL be rejected (remain IDLE, pulse cfg_err_o) if e_col_i<s_col_i, e_row_i<s_row_i, or bpp_i=0.
REQ-010 HRST: vld=1, hrst=1; on handshake load the stall counter with RST_STALL_CYC-1 and go to STALL.
REQ-011 STALL: vld=0; decrement each cycle; when the counter is 0, go to ACS (exactly RST_STALL_CYC cycles in STALL).
REQ-012 ACS: typ=addr_acs_ctrl_i, dat=cmd_acs_ctrl_i, last=1; on handshake go to COL.
REQ-013 COL: 4 beats, typ=addr_col_i, dat in order s_col[15:8], s_col[7:0], e_col[15:8], e_col[7:0] (zero-extended when COORD_W<16); last on beat 4; then go to ROW.
REQ-014 ROW: same 4-beat layout with the row bounds; last on beat 4; then go to DISP if this is the first frame of an init_mode sequence, else MEMWR.
REQ-015 DISP: typ=addr_disp_on_i, no_dat=1, last=1; on handshake go to MEMWR.
REQ-016 On entry to MEMWR, total bytes SHALL be N=(e_col-s_col+1)*(e_row-s_row+1)*bpp, computed in CNT_W bits with no overflow.
REQ-017 MEMWR: typ=addr_mem_wr_i, dat=pxl_d_i, vld=pxl_vld_i, pxl_rdy_o=dtp_tx_rdy_i; pxl_rdy_o SHALL be 0 in every other state.
REQ-018 MEMWR: the counter increments only on handshake; last=1 when count=N-1.
REQ-019 On the last MEMWR handshake: pulse frame_done_o and reset the counter. If cont_i was latched 1, start_i=1 and no stop is pending, re-latch the window/bpp and go to COL; otherwise go to IDLE.
REQ-020 stop_i SHALL set a sticky pending flag in any non-IDLE state; the flag takes effect only at frame end and clears on entry to IDLE.
REQ-021 A frame of N=1 SHALL assert last on its single beat.
REQ-022 Changes to s_/e_col_i, s_/e_row_i or bpp_i mid-frame SHALL have no effect until the next re-latch.
REQ-023 start_i deassertion mid-frame SHALL NOT abort the frame.

Reset
REQ-024 While rst=1 at a clk edge: state becomes IDLE; counters, stop flag and latched configuration clear; all outputs become 0 from the next cycle, including mid-frame and mid-stall.
REQ-025 The first start after reset SHALL be handled like any start.

Verification
REQ-026 RST_STALL_CYC=4, init_mode=1, window 0..1 x 0..1, bpp=2, rdy=1 -> HRST, 4 stall cycles, ACS, 4 COL, 4 ROW, DISP, 8 MEMWR beats, last on beat 8, one frame_done, IDLE.
REQ-027 init_mode=0, cont=1, 3 frames, then stop_i pulsed mid-frame 3 -> no HRST/ACS/DISP; frame 3 completes; IDLE after frame 3.
REQ-028 e_col<s_col with start -> one cfg_err pulse, busy stays 0, no vld.
REQ-029 Random rdy/pxl_vld stalls, window 5..9 x 2..3, bpp=3 -> exactly 30 pixel handshakes, data order preserved, no beat dropped.
REQ-030 rst asserted in STALL and in MEMWR -> next cycle all outputs 0; a new start runs from HRST.
REQ-031 Window and bpp changed during MEMWR with cont=1 -> current frame uses the old values; the next frame's COL/ROW bytes and N use the new values.
